// File: rtl/ssd_pkg.sv
// Shared types and the 7-segment pattern table for the keypad-entry display path.
package ssd_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Segment order is {g,f,e,d,c,b,a}, active-high, indexed by hex value.
    localparam seg_t SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup covers all 16 codes, so no fall-through value is needed.
    always_comb begin
        seg = SEG_LUT[hex];
    end

endmodule

// File: rtl/ssd_kypd_entry_mux.sv
// N-digit keypad entry buffer multiplexed onto a shared 7-segment bus.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits not yet entered.
module ssd_kypd_entry_mux
    import ssd_pkg::*;
#(
    parameter int         NUM_DIGITS  = 2,
    parameter int         REFRESH_DIV = 100_000,
    parameter logic [3:0] CLR_KEY     = 4'hC,
    parameter logic [3:0] BKSP_KEY    = 4'hB
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [3:0]                       key_code,
    input  logic                             key_valid,
    input  logic                             scan_en,
    input  logic                             step_pulse,
    output logic [6:0]                       seg,
    output logic [NUM_DIGITS-1:0]            dig_sel,
    output logic [4*NUM_DIGITS-1:0]          buf_val,
    output logic [$clog2(NUM_DIGITS+1)-1:0]  entry_cnt
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int BUF_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [REF_W-1:0]      REF_ZERO = {REF_W{1'b0}};
    localparam logic [REF_W-1:0]      REF_ONE  = REF_W'(1);
    localparam logic [REF_W-1:0]      REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);
`ifdef LEADING_ZERO_BLANK_EN
    localparam seg_t SEG_RST = SEG_BLANK;
`else
    localparam seg_t SEG_RST = SEG_LUT[0];
`endif

    logic                  key_valid_q_r;
    logic [BUF_W-1:0]      buf_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [REF_W-1:0]      refresh_r;
    logic [NUM_DIGITS-1:0] dig_sel_r;
    seg_t                  seg_r;

    logic                  key_evt_s;
    logic                  adv_s;
    logic [BUF_W-1:0]      buf_nxt_s;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic [REF_W-1:0]      refresh_nxt_s;
    logic [NUM_DIGITS-1:0] dig_sel_nxt_s;
    logic [3:0]            dig_nib_s;
    seg_t                  dig_seg_s;
    logic                  blank_s;
    seg_t                  seg_nxt_s;

    assign key_evt_s = key_valid & ~key_valid_q_r;

    // Buffer and entry count update on a key press edge.
    always_comb begin
        buf_nxt_s = buf_r;
        cnt_nxt_s = cnt_r;
        if (key_evt_s) begin
            if (key_code == CLR_KEY) begin
                buf_nxt_s = {BUF_W{1'b0}};
                cnt_nxt_s = CNT_ZERO;
            end else if (key_code == BKSP_KEY) begin
                buf_nxt_s = {4'h0, buf_r[BUF_W-1:4]};
                cnt_nxt_s = (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
            end else begin
                buf_nxt_s = {buf_r[BUF_W-5:0], key_code};
                cnt_nxt_s = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
            end
        end else begin
            buf_nxt_s = buf_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Digit advance: dwell counter in auto-scan, step pulses otherwise.
    always_comb begin
        refresh_nxt_s = REF_ZERO;
        adv_s         = 1'b0;
        if (scan_en) begin
            if (refresh_r == REF_LAST) begin
                refresh_nxt_s = REF_ZERO;
                adv_s         = 1'b1;
            end else begin
                refresh_nxt_s = refresh_r + REF_ONE;
                adv_s         = 1'b0;
            end
        end else begin
            refresh_nxt_s = REF_ZERO;
            adv_s         = step_pulse;
        end
    end

    // Digit index with wrap back to digit 0.
    always_comb begin
        idx_nxt_s = idx_r;
        if (adv_s) begin
            idx_nxt_s = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Outputs are built from next-state values so select and segments move together.
    assign dig_sel_nxt_s = SEL_ONE << idx_nxt_s;
    assign dig_nib_s     = buf_nxt_s[{idx_nxt_s, 2'b00} +: 4];

    ssd_hex_decode u_hex_decode (
        .hex (dig_nib_s),
        .seg (dig_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digits above the entered count are dark; digit 0 only when nothing is entered.
    always_comb begin
        blank_s = 1'b0;
        if (idx_nxt_s == IDX_ZERO) begin
            blank_s = (cnt_nxt_s == CNT_ZERO);
        end else begin
            blank_s = (32'(idx_nxt_s) >= 32'(cnt_nxt_s));
        end
    end
`else
    assign blank_s = 1'b0;
`endif

    assign seg_nxt_s = blank_s ? SEG_BLANK : dig_seg_s;

    // State and output registers; key history resets high to ignore a held key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid_q_r <= 1'b1;
            buf_r         <= {BUF_W{1'b0}};
            cnt_r         <= CNT_ZERO;
            idx_r         <= IDX_ZERO;
            refresh_r     <= REF_ZERO;
            dig_sel_r     <= SEL_ONE;
            seg_r         <= SEG_RST;
        end else begin
            key_valid_q_r <= key_valid;
            buf_r         <= buf_nxt_s;
            cnt_r         <= cnt_nxt_s;
            idx_r         <= idx_nxt_s;
            refresh_r     <= refresh_nxt_s;
            dig_sel_r     <= dig_sel_nxt_s;
            seg_r         <= seg_nxt_s;
        end
    end

    assign seg       = seg_r;
    assign dig_sel   = dig_sel_r;
    assign buf_val   = buf_r;
    assign entry_cnt = cnt_r;

endmodule

// File: doc/ssd_kypd_entry_mux.md
Name: ssd_kypd_entry_mux

Overview:
- Parametrised multi-digit keypad-entry display controller. Generalises the fixed two-digit Pmod SSD path.
- Captures one decoded key code per keypad press into an N-digit shift buffer.
- Time-multiplexes the buffer onto a shared 7-segment bus with one-hot digit selects.
- Sits between the keypad decoder (key_code / key_valid) and the SSD pins. Supports auto-scan or manual step mode.

Parameters:
- NUM_DIGITS, 2, number of display digits; 2..8.
- REFRESH_DIV, 100_000, clk cycles each digit is held in auto-scan; at least 2.
- CLR_KEY, 4'hC, key code that clears the buffer.
- BKSP_KEY, 4'hB, key code that deletes the newest digit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_code  in  4  decoded key value from the keypad decoder.
- key_valid  in  1  level, high while a key is held; synchronous to clk.
- scan_en  in  1  1 = auto-scan, 0 = manual step.
- step_pulse  in  1  single-cycle pulse; advances the digit in manual mode.
- seg  out  7  segments a..g, active-high.
- dig_sel  out  NUM_DIGITS  one-hot digit enable, active-high.
- buf_val  out  4*NUM_DIGITS  full buffer contents; digit 0 is in bits [3:0].
- entry_cnt  out  $clog2(NUM_DIGITS+1)  number of digits entered, saturating.

Behaviour:
- Reset:
  - Buffer cleared to all 0.
  - entry_cnt = 0; digit index = 0; dig_sel = 1 (digit 0); seg = decode of 0 (7'h3F, or blank with the optional feature).
  - Refresh counter = 0.
  - key_valid history register resets to 1, so a key held through reset release is not captured.
- Key capture:
  - key_evt = key_valid & ~key_valid_q.
  - Exactly one event per press, regardless of hold duration.
- On key_evt, the next cycle's registered state is updated by key_code:
  - CLR_KEY: buffer set to all 0; entry_cnt = 0.
  - BKSP_KEY: buffer shifts toward digit 0 (digit i takes digit i+1); top digit becomes 0; entry_cnt decrements, saturating at 0.
  - Any other code: buffer shifts away from digit 0; the new code enters digit 0; the oldest digit is discarded; entry_cnt increments, saturating at NUM_DIGITS.
- Capture latency: buf_val and entry_cnt update 1 cycle after the key_evt cycle. seg reflects the change when that digit is next selected.
- Auto-scan (scan_en = 1):
  - Refresh counter runs 0..REFRESH_DIV-1.
  - At terminal count the digit index advances, wrapping NUM_DIGITS-1 to 0. Each digit is held exactly REFRESH_DIV cycles.
  - step_pulse is ignored.
- Manual mode (scan_en = 0):
  - Refresh counter is held at 0.
  - Each step_pulse advances the digit index with the same wrap.
- Mode change: switching scan_en 0 to 1 restarts the dwell from count 0 on the current digit. The index is preserved.
- Outputs:
  - dig_sel and seg are registered. Both change on the same edge: no ghosting cycle in which a new select pairs with old segment data.
  - Hex decode covers 0-F with the standard a..g patterns: 0=3F, 1=06, 8=7F, A=77, F=71.
- Simultaneous events: key_evt and a digit advance in the same cycle are independent and both take effect.
- Reset mid-scan or mid-entry returns all state to reset values immediately, asynchronously.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i drives seg = 7'h00 when i >= entry_cnt and i != 0.
  - Digit 0 is blank only when entry_cnt == 0.
  - dig_sel still scans normally.
- Undefined: all digits always show their hex value, zeros included.

Decomposition:
- Package ssd_pkg:
  - typedef nibble_t (logic [3:0]); typedef seg_t (logic [6:0]).
  - Constant SEG_BLANK = 7'h00.
  - Function-free hex pattern table constant SEG_LUT[16].
- Sub-module: ssd_hex_decode, combinational nibble_t to seg_t. Instantiated once on the selected digit ahead of the seg output register.

Test Plan (NUM_DIGITS = 4, REFRESH_DIV = 4):
- Keys 1, 2, 3 pressed (key_valid held 5 cycles each) -> buf_val = 16'h0123, entry_cnt = 3; only one capture per press.
- Keys 1..5 -> buf_val = 16'h2345, entry_cnt = 4 (saturated, oldest digit dropped). Then BKSP -> 16'h0234, entry_cnt = 3. Then CLR -> 16'h0000, entry_cnt = 0.
- Auto-scan, buffer 16'hA1F8 -> dig_sel sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles. seg matches per digit: 7F, 71, 06, 77.
- scan_en = 0 -> dig_sel frozen for 20 cycles. Three step_pulses -> 0010, 0100, 1000. A fourth -> wraps to 0001.
- key_valid = 1 across rst_n release -> no capture until key_valid falls and rises again. rst_n asserted mid-entry -> buf_val = 0 and dig_sel = 0001 with no clock edge.
- With LEADING_ZERO_BLANK_EN and entry 16'h0007 (entry_cnt = 1) -> digits 1-3 seg = 00, digit 0 seg = 07. After CLR, digit 0 seg = 00.
